// File: rtl/lbm_arb_pkg.sv
// Shared types and helpers for the four-requester LBM round-robin arbiter.
package lbm_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [1:0] req_idx_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // First set bit of valid, scanning upward from start with wrap 3->0.
    function automatic req_idx_t rr_pick(input logic [NUM_REQ-1:0] valid, input req_idx_t start);
        req_idx_t pick;
        req_idx_t cand;
        logic     found;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = start + req_idx_t'(k);
            if (!found && valid[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/lbm_rr_arbiter4_mux4.sv
// 4:1 payload select for the shared LBM datapath port.
module lbm_rr_arbiter4_mux4
    import lbm_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  req_idx_t                  sel,
    input  logic signed [WIDTH-1:0]   d0,
    input  logic signed [WIDTH-1:0]   d1,
    input  logic signed [WIDTH-1:0]   d2,
    input  logic signed [WIDTH-1:0]   d3,
    output logic signed [WIDTH-1:0]   y
);

    always_comb begin
        unique case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/lbm_rr_arbiter4.sv
// Four-way round-robin arbiter with a one-entry registered output stage.
// Optional burst locking (owner keeps the grant up to MAX_BURST beats) with LBM_ARB_BURST_LOCK_EN.
module lbm_rr_arbiter4
    import lbm_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [3:0]                   req_valid,
    input  logic signed [DATA_WIDTH-1:0] req_data0,
    input  logic signed [DATA_WIDTH-1:0] req_data1,
    input  logic signed [DATA_WIDTH-1:0] req_data2,
    input  logic signed [DATA_WIDTH-1:0] req_data3,
    output logic [3:0]                   req_ready,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic [1:0]                   out_src,
    input  logic                         out_ready
);

    if (MAX_BURST < 1) begin : g_bad_burst
        $error("MAX_BURST must be at least 1");
    end

    logic                         r_out_valid;
    logic signed [DATA_WIDTH-1:0] r_out_data;
    req_idx_t                     r_out_src;
    req_idx_t                     r_rr_ptr;
    req_idx_t                     w_rr_ptr_nxt;
    req_idx_t                     w_winner;
    logic                         w_load_en;
    logic                         w_xfer;
    logic signed [DATA_WIDTH-1:0] w_mux_data;

    assign w_load_en = !r_out_valid || out_ready;
    assign w_xfer    = (|req_valid) && w_load_en && !reset;
    assign req_ready = w_xfer ? (4'b0001 << w_winner) : 4'b0000;

`ifdef LBM_ARB_BURST_LOCK_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    req_idx_t         r_owner;
    req_idx_t         w_owner_nxt;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_hold;

    // A lapsed owner releases the grant in the same cycle; the others are searched from owner+1.
    assign w_hold   = (r_state == LOCKED) && req_valid[r_owner];
    assign w_winner = w_hold ? r_owner
                             : rr_pick(req_valid, (r_state == LOCKED) ? req_idx_t'(r_owner + 2'd1) : r_rr_ptr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_burst_cnt <= w_cnt_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_cnt_nxt    = r_burst_cnt;
        w_rr_ptr_nxt = r_rr_ptr;
        if (w_hold) begin
            if (w_xfer) begin
                if (r_burst_cnt == CNT_W'(MAX_BURST - 1)) begin
                    w_state_nxt  = IDLE;
                    w_cnt_nxt    = '0;
                    w_rr_ptr_nxt = r_owner + 2'd1;
                end else begin
                    w_cnt_nxt = r_burst_cnt + CNT_W'(1);
                end
            end
        end else begin
            if (r_state == LOCKED) begin
                w_state_nxt  = IDLE;
                w_cnt_nxt    = '0;
                w_rr_ptr_nxt = r_owner + 2'd1;
            end
            if (w_xfer) begin
                if (MAX_BURST == 1) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = w_winner + 2'd1;
                end else begin
                    w_state_nxt = LOCKED;
                    w_owner_nxt = w_winner;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
        end
    end
`else
    assign w_winner = rr_pick(req_valid, r_rr_ptr);

    always_comb begin
        w_rr_ptr_nxt = r_rr_ptr;
        if (w_xfer) begin
            w_rr_ptr_nxt = w_winner + 2'd1;
        end
    end
`endif

    lbm_rr_arbiter4_mux4 #(
        .WIDTH (DATA_WIDTH)
    ) u_mux (
        .sel (w_winner),
        .d0  (req_data0),
        .d1  (req_data1),
        .d2  (req_data2),
        .d3  (req_data3),
        .y   (w_mux_data)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_rr_ptr <= w_rr_ptr_nxt;
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_mux_data;
                r_out_src   <= w_winner;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_lbm_rr_arbiter4.sv
// Scoreboard bench for lbm_rr_arbiter4; expectations follow LBM_ARB_BURST_LOCK_EN when defined.
module tb_lbm_rr_arbiter4;

    localparam int DW = 32;

    typedef struct packed {
        logic [1:0]          src;
        logic signed [DW-1:0] data;
    } beat_t;

    logic                 clk;
    logic                 reset;
    logic [3:0]           req_valid;
    logic signed [DW-1:0] d [4];
    logic [3:0]           req_ready;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic [1:0]           out_src;
    logic                 out_ready;

    beat_t exp_q[$];
    beat_t last_beat;
    int    n_checks = 0;
    int    n_errors = 0;

    lbm_rr_arbiter4 #(
        .DATA_WIDTH (DW),
        .MAX_BURST  (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data0 (d[0]),
        .req_data1 (d[1]),
        .req_data2 (d[2]),
        .req_data3 (d[3]),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one granted cycle per entry of seq; inputs already driven, called just after a negedge.
    task automatic run_grants(input string name, input int seq[$], input bit first_check_idle);
        beat_t got;
        foreach (seq[k]) begin
            exp_q.push_back('{src: 2'(seq[k]), data: d[seq[k]]});
            #1;
            if (first_check_idle && k == 0) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s latency: out_valid=%0b before first edge, expected 0", name, out_valid);
                end
            end
            n_checks++;
            if (req_ready !== (4'b0001 << seq[k])) begin
                n_errors++;
                $display("FAIL %s req_ready[%0d]: got %b expected grant to %0d", name, k, req_ready, seq[k]);
            end
            @(posedge clk); #1;
            got = exp_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || out_src !== got.src || out_data !== got.data) begin
                n_errors++;
                $display("FAIL %s beat[%0d]: got v=%0b src=%0d data=%0d expected v=1 src=%0d data=%0d",
                         name, k, out_valid, out_src, out_data, got.src, got.data);
            end
            last_beat = got;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset req_ready: got %b expected 0000", req_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_src !== 2'd0) begin
            n_errors++;
            $display("FAIL reset outputs: got v=%0b data=%0d src=%0d expected 0/0/0", out_valid, out_data, out_src);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_rotation();
        int seq[$];
`ifdef LBM_ARB_BURST_LOCK_EN
        seq = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
`else
        seq = '{0, 1, 2, 3, 0};
`endif
        req_valid = 4'b1111;
        out_ready = 1'b1;
        run_grants("rotation", seq, 1'b1);
    endtask

    task automatic test_single();
        int seq[$];
        seq = '{2, 2, 2};
        d[2] = -1;
        req_valid = 4'b0100;
        run_grants("single", seq, 1'b0);
        n_checks++;
        if (out_data !== {DW{1'b1}}) begin
            n_errors++;
            $display("FAIL single sign: got %h expected all ones", out_data);
        end
        d[2] = 30;
    endtask

    task automatic test_backpressure();
        beat_t got;
        out_ready = 1'b0;
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0000) begin
                n_errors++;
                $display("FAIL stall req_ready[%0d]: got %b expected 0000", c, req_ready);
            end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_src !== last_beat.src || out_data !== last_beat.data) begin
                n_errors++;
                $display("FAIL stall hold[%0d]: got v=%0b src=%0d data=%0d expected v=1 src=%0d data=%0d",
                         c, out_valid, out_src, out_data, last_beat.src, last_beat.data);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        exp_q.push_back('{src: 2'd3, data: d[3]});
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_errors++;
            $display("FAIL release req_ready: got %b expected 1000", req_ready);
        end
        @(posedge clk); #1;
        got = exp_q.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || out_src !== got.src || out_data !== got.data) begin
            n_errors++;
            $display("FAIL release beat: got v=%0b src=%0d data=%0d expected v=1 src=%0d data=%0d",
                     out_valid, out_src, out_data, got.src, got.data);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL drain: got out_valid=%0b expected 0", out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_alt_and_reset();
        int    seq[$];
        beat_t got;
`ifdef LBM_ARB_BURST_LOCK_EN
        seq = '{1, 1, 1};
`else
        seq = '{1, 3, 1};
`endif
        req_valid = 4'b1010;
        out_ready = 1'b1;
        run_grants("alternate", seq, 1'b0);
        reset = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_errors++;
            $display("FAIL midreset req_ready: got %b expected 0000", req_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset out_valid: got %0b expected 0", out_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back('{src: 2'd1, data: d[1]});
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_errors++;
            $display("FAIL postreset req_ready: got %b expected 0010", req_ready);
        end
        @(posedge clk); #1;
        got = exp_q.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || out_src !== got.src || out_data !== got.data) begin
            n_errors++;
            $display("FAIL postreset beat: got v=%0b src=%0d data=%0d expected v=1 src=%0d data=%0d",
                     out_valid, out_src, out_data, got.src, got.data);
        end
        @(negedge clk);
        req_valid = 4'b0000;
    endtask

`ifdef LBM_ARB_BURST_LOCK_EN
    task automatic test_burst_drop();
        int seq_a[$];
        int seq_b[$];
        seq_a = '{0, 0};
        seq_b = '{1, 1};
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 4'b1111;
        run_grants("lock_hold", seq_a, 1'b0);
        req_valid = 4'b1110;
        run_grants("lock_drop", seq_b, 1'b0);
        req_valid = 4'b0000;
    endtask
`endif

    initial begin
        reset     = 1'b1;
        req_valid = 4'b0000;
        out_ready = 1'b1;
        d[0] = 10;
        d[1] = -20;
        d[2] = 30;
        d[3] = -40;
        last_beat = '0;
        test_reset();
        test_rotation();
        test_single();
        test_backpressure();
        test_alt_and_reset();
`ifdef LBM_ARB_BURST_LOCK_EN
        test_burst_drop();
`endif
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard: %0d beats left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
